// File: rtl/led_axi_ctrl.sv
// led_axi_ctrl: AXI4-Lite slave with four 32-bit registers driving a bank of LEDs.
// The registers are CTRL (EN, BLINK), PATTERN, PERIOD and DUTY.
// A blink engine gates the LEDs on and off.
// Optional macro LED_PWM_EN adds an 8-bit PWM dimmer controlled by DUTY[7:0].
// Without that macro, DUTY is plain storage and has no effect on the LEDs.
module led_axi_ctrl #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned LED_WIDTH          = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [LED_WIDTH-1:0]              led
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] SEL_CTRL    = 2'd0;
    localparam logic [1:0] SEL_PATTERN = 2'd1;
    localparam logic [1:0] SEL_PERIOD  = 2'd2;
    localparam logic [1:0] SEL_DUTY    = 2'd3;

    logic                 r_awready;
    logic                 r_bvalid;
    logic                 r_arready;
    logic                 r_rvalid;
    logic [DW-1:0]        r_rdata;
    logic [DW-1:0]        r_ctrl;
    logic [DW-1:0]        r_pattern;
    logic [DW-1:0]        r_period;
    logic [DW-1:0]        r_duty;
    logic [DW-1:0]        r_blink_cnt;
    logic                 r_phase;
    logic [LED_WIDTH-1:0] r_led;

    logic                 w_wr_hs;
    logic                 w_rd_hs;
    logic [1:0]           w_wr_sel;
    logic [1:0]           w_rd_sel;
    logic                 w_en;
    logic                 w_blink_run;
    logic                 w_timer_clr;
    logic [DW-1:0]        w_period_m1;
    logic [DW-1:0]        w_rd_mux;
    logic [LED_WIDTH-1:0] w_pwm_mask;
    logic                 w_unused_ok;

    // Merge the byte lanes enabled in strb into the old register value
    function automatic logic [DW-1:0] f_apply_strb(input logic [DW-1:0] old_val,
                                                   input logic [DW-1:0] data,
                                                   input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(SW); b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = data[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign w_wr_hs     = r_awready && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_rd_hs     = r_arready && S_AXI_ARVALID;
    assign w_wr_sel    = S_AXI_AWADDR[3:2];
    assign w_rd_sel    = S_AXI_ARADDR[3:2];
    assign w_en        = r_ctrl[0];
    assign w_blink_run = r_ctrl[0] && r_ctrl[1];
    assign w_timer_clr = w_wr_hs && ((w_wr_sel == SEL_CTRL) || (w_wr_sel == SEL_PERIOD));
    assign w_period_m1 = (r_period == '0) ? '0 : r_period - DW'(1);
    assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign led           = r_led;

    // Read-data selection from the current (pre-write) register values
    always_comb begin
        w_rd_mux = '0;
        case (w_rd_sel)
            SEL_CTRL:    w_rd_mux = r_ctrl;
            SEL_PATTERN: w_rd_mux = r_pattern;
            SEL_PERIOD:  w_rd_mux = r_period;
            SEL_DUTY:    w_rd_mux = r_duty;
        endcase
    end

    // Write channel: joint AW/W acceptance pulse and write response
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_awready <= S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid && !r_awready;
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: address acceptance, data capture and hold until RREADY
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= S_AXI_ARVALID && !r_rvalid && !r_arready;
            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Register file with byte-lane write strobes
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_ctrl    <= '0;
            r_pattern <= '0;
            r_period  <= '0;
            r_duty    <= DW'(32'h0000_00FF);
        end else if (w_wr_hs) begin
            case (w_wr_sel)
                SEL_CTRL:    r_ctrl    <= f_apply_strb(r_ctrl,    S_AXI_WDATA, S_AXI_WSTRB);
                SEL_PATTERN: r_pattern <= f_apply_strb(r_pattern, S_AXI_WDATA, S_AXI_WSTRB);
                SEL_PERIOD:  r_period  <= f_apply_strb(r_period,  S_AXI_WDATA, S_AXI_WSTRB);
                SEL_DUTY:    r_duty    <= f_apply_strb(r_duty,    S_AXI_WDATA, S_AXI_WSTRB);
            endcase
        end
    end

    // Blink engine: half-period counter toggling the on/off phase
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_timer_clr || !w_blink_run) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt >= w_period_m1) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + DW'(1);
        end
    end

`ifdef LED_PWM_EN
    logic [7:0] r_pwm_cnt;

    // Free-running PWM counter, advancing only while the LEDs are enabled
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_pwm_cnt <= '0;
        end else if (w_en) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    assign w_pwm_mask = (r_pwm_cnt < r_duty[7:0]) ? '1 : '0;
`else
    assign w_pwm_mask = '1;
`endif

    // Registered LED drive
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_led <= '0;
        end else if (w_en) begin
            r_led <= r_pattern[LED_WIDTH-1:0] & {LED_WIDTH{r_phase}} & w_pwm_mask;
        end else begin
            r_led <= '0;
        end
    end

endmodule

// File: tb/tb_led_axi_ctrl.sv
// Self-checking bench for led_axi_ctrl.
// A register model supplies expected read data.
// Expected bus responses go into a scoreboard queue and are popped when the DUT responds.
module tb_led_axi_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b1;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [7:0]  led;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] m_reg[4];

    always #5 ACLK = ~ACLK;

    led_axi_ctrl #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .LED_WIDTH(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .led(led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_pop_check(input string tag, input logic [31:0] got);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            check(tag, got, sb_q.pop_front());
        end
    endtask

    task automatic model_reset();
        m_reg[0] = 32'h0;
        m_reg[1] = 32'h0;
        m_reg[2] = 32'h0;
        m_reg[3] = 32'h0000_00FF;
    endtask

    task automatic model_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        @(negedge ACLK);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!awready && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (!awready) begin
            check("aw_timeout", 32'd0, 32'd1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        check("wready_with_awready", 32'(wready), 32'd1);
        @(posedge ACLK);
        model_write(a[3:2], d, s);
        sb_q.push_back(32'h0);
        @(negedge ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        if (!bvalid) begin
            check("bvalid_rise", 32'd0, 32'd1);
            void'(sb_q.pop_back());
        end else begin
            sb_pop_check("bresp", 32'(bresp));
        end
    endtask

    task automatic axi_read(input logic [3:0] a);
        int n;
        n = 0;
        @(negedge ACLK);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (!arready) begin
            check("ar_timeout", 32'd0, 32'd1);
            arvalid = 1'b0;
            return;
        end
        @(posedge ACLK);
        sb_q.push_back(m_reg[a[3:2]]);
        @(negedge ACLK);
        arvalid = 1'b0;
        if (!rvalid) begin
            check("rvalid_rise", 32'd0, 32'd1);
            void'(sb_q.pop_back());
        end else begin
            check("rresp", 32'(rresp), 32'd0);
            sb_pop_check("rdata", rdata);
        end
    endtask

    initial begin
        int n;
        int cnt;
        logic [31:0] held;
        model_reset();
        #1 ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        check("rst_led", 32'(led), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        ARESETN = 1'b1;

        // reset values via the bus
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4));

        // basic write / readback
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4));

        // byte strobes, zero strobe, ignored low address bits
        axi_write(4'h4, 32'h0000_0002, 4'hF);
        axi_write(4'h4, 32'hAABB_CCDD, 4'b0010);
        axi_read(4'h4);
        axi_write(4'h8, 32'hFFFF_FFFF, 4'b0000);
        axi_read(4'hB);
        axi_write(4'h7, 32'h8000_0001, 4'hF);
        axi_read(4'h4);

        // enable timing: led follows two edges after the CTRL handshake
        axi_write(4'h0, 32'h0, 4'hF);
        @(negedge ACLK);
        check("led_disabled", 32'(led), 32'd0);
        axi_write(4'h4, 32'hA5, 4'hF);
        axi_write(4'hC, 32'hFF, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        check("led_before_latency", 32'(led), 32'd0);
        @(negedge ACLK);
        check("led_enabled", 32'(led), 32'hA5);
        axi_write(4'h0, 32'h0, 4'hF);
        @(negedge ACLK);
        check("led_off_again", 32'(led), 32'd0);

        // blink with PERIOD=4, then PERIOD=0
        axi_write(4'h4, 32'hFF, 4'hF);
        axi_write(4'h8, 32'h4, 4'hF);
        axi_write(4'h0, 32'h3, 4'hF);
        for (int k = 1; k <= 16; k++) begin
            @(negedge ACLK);
            check("blink_p4", 32'(led), (((k - 1) / 4) % 2 == 0) ? 32'hFF : 32'h0);
        end
        axi_write(4'h8, 32'h0, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            @(negedge ACLK);
            check("blink_p0", 32'(led), ((k - 1) % 2 == 0) ? 32'hFF : 32'h0);
        end

        // read and write of PERIOD handshake on the same edge: read sees old value
        @(negedge ACLK);
        awaddr = 4'h8; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 4'h8; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("same_edge_aw", 32'(awready), 32'd1);
        check("same_edge_ar", 32'(arready), 32'd1);
        @(posedge ACLK);
        sb_q.push_back(m_reg[2]);
        model_write(2'd2, 32'h55, 4'hF);
        sb_q.push_back(32'h0);
        @(negedge ACLK);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        if (rvalid) sb_pop_check("same_edge_rdata", rdata);
        else begin check("same_edge_rvalid", 32'd0, 32'd1); void'(sb_q.pop_front()); end
        if (bvalid) sb_pop_check("same_edge_bresp", 32'(bresp));
        else begin check("same_edge_bvalid", 32'd0, 32'd1); void'(sb_q.pop_front()); end
        axi_read(4'h8);

        // write-response backpressure: second write must wait
        @(negedge ACLK);
        awaddr = 4'h4; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("bp_w_accept", 32'(awready), 32'd1);
        @(posedge ACLK);
        model_write(2'd1, 32'h1234_5678, 4'hF);
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            wdata = 32'hDEAD_BEEF;
            check("bp_bvalid_hold", 32'(bvalid), 32'd1);
            check("bp_awready_low", 32'(awready), 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge ACLK);
        check("bp_bvalid_clear", 32'(bvalid), 32'd0);
        axi_read(4'h4);

        // read-data backpressure: RDATA held while address changes underneath
        @(negedge ACLK);
        araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("bp_r_accept", 32'(arready), 32'd1);
        @(posedge ACLK);
        held = m_reg[1];
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            araddr = 4'h0;
            check("bp_rvalid_hold", 32'(rvalid), 32'd1);
            check("bp_rdata_hold", rdata, held);
            check("bp_arready_low", 32'(arready), 32'd0);
        end
        arvalid = 1'b0; rready = 1'b1;
        @(negedge ACLK);
        check("bp_rvalid_clear", 32'(rvalid), 32'd0);

        // reset mid-blink with a write pending
        axi_write(4'h8, 32'h4, 4'hF);
        axi_write(4'h4, 32'hFF, 4'hF);
        axi_write(4'h0, 32'h3, 4'hF);
        repeat (2) @(negedge ACLK);
        check("pre_reset_led_on", 32'(led), 32'hFF);
        awaddr = 4'hC; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        #2 ARESETN = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'd0);
        check("async_rst_awready", 32'(awready), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        model_reset();
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("post_rst_bvalid", 32'(bvalid), 32'd0);
            check("post_rst_rvalid", 32'(rvalid), 32'd0);
        end
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4));
        check("post_rst_led", 32'(led), 32'd0);

`ifdef LED_PWM_EN
        // PWM duty 64/256 then fully dark
        axi_write(4'h4, 32'h01, 4'hF);
        axi_write(4'hC, 32'd64, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        @(negedge ACLK);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge ACLK);
            cnt += int'(led[0]);
        end
        check("pwm_duty64", 32'(cnt), 32'd64);
        axi_write(4'hC, 32'd0, 4'hF);
        @(negedge ACLK);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge ACLK);
            cnt += int'(led[0]);
        end
        check("pwm_duty0", 32'(cnt), 32'd0);
`else
        cnt = 0;
        check("sb_drained", 32'(sb_q.size()), 32'(cnt));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
